tdc_sample_ctrl: RTL and testbench

- Sequencer for the SRAM22 time-to-digital converter macro (start input a, stop input b, active-low reset_b, 252-bit thermometer dout).
- Per sample: resets the TDC, launches a start edge, waits a programmable number of clock cycles, issues the stop edge, then captures and decodes dout.
- Runs a burst of N samples and accumulates last/min/max/sum results for the BIST/scan-chain readout logic.
- Sits between the BIST control registers and the TDC hard macro.

---
 rtl/tdc_sample_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_tdc_sample_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_sample_ctrl
//
// Sequencer for the SRAM22 time-to-digital converter macro. Each sample:
// hold the TDC in reset, release it, launch the start edge (tdc_a), wait a
// programmable number of cycles, issue the stop edge (tdc_b), let the
// thermometer output settle, capture it and decode it by population count.
// A burst of N samples is run and last/min/max/sum results are accumulated
// for the BIST / scan-chain readout.
//
// Optional feature (macro TDC_BUBBLE_CHECK_EN): adds bubble_err (sticky,
// cleared on start) and bubble_cnt (saturating). Each captured word is
// checked for being a clean thermometer code 0..01..1. Decoding still uses
// popcount either way.
//
// Ports:
//   clk           controller clock
//   reset_b       synchronous active-low reset
//   start         one-cycle burst request, honoured only in IDLE
//   abort         cancel the burst in progress (wins over start in IDLE)
//   num_samples   samples per burst, 0 behaves as 1, latched on start
//   delay_cycles  start-to-stop wait cycles, latched on start
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse at burst completion
//   tdc_a         TDC start edge
//   tdc_b         TDC stop edge
//   tdc_reset_b   TDC active-low reset (held low while idle)
//   tdc_dout      TDC thermometer output
//   result_last   most recent decoded sample
//   result_min    burst minimum
//   result_max    burst maximum
//   result_sum    burst sum
//   sample_cnt    samples completed in the current / last burst
//   bubble_err    (TDC_BUBBLE_CHECK_EN) sticky non-thermometer flag
//   bubble_cnt    (TDC_BUBBLE_CHECK_EN) saturating non-thermometer count
// -----------------------------------------------------------------------------
module tdc_sample_ctrl #(
    parameter int TDC_WIDTH     = 252,
    parameter int CODE_W        = 8,
    parameter int NS_W          = 8,
    parameter int DLY_W         = 4,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NS_W-1:0]        num_samples,
    input  logic [DLY_W-1:0]       delay_cycles,
    output logic                   busy,
    output logic                   done,
    output logic                   tdc_a,
    output logic                   tdc_b,
    output logic                   tdc_reset_b,
    input  logic [TDC_WIDTH-1:0]   tdc_dout,
    output logic [CODE_W-1:0]      result_last,
    output logic [CODE_W-1:0]      result_min,
    output logic [CODE_W-1:0]      result_max,
    output logic [CODE_W+NS_W-1:0] result_sum,
    output logic [NS_W-1:0]        sample_cnt
`ifdef TDC_BUBBLE_CHECK_EN
    ,
    output logic                   bubble_err,
    output logic [NS_W-1:0]        bubble_cnt
`endif
);

    // Counter wide enough for RST_CYCLES, SETTLE_CYCLES and the delay range.
    localparam int CNT_W = 16;
    localparam int SUM_W = CODE_W + NS_W;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RST     = 4'd1,
        S_ARM     = 4'd2,
        S_LAUNCH  = 4'd3,
        S_WAIT    = 4'd4,
        S_STOP    = 4'd5,
        S_CAPTURE = 4'd6,
        S_ACCUM   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    // Control output vector packed as {busy, done, tdc_reset_b, tdc_a, tdc_b}.
    function automatic logic [4:0] ctl_for(input state_t s);
        logic [4:0] c;
        case (s)
            S_IDLE:    c = 5'b00000;
            S_RST:     c = 5'b10000;
            S_ARM:     c = 5'b10100;
            S_LAUNCH:  c = 5'b10110;
            S_WAIT:    c = 5'b10110;
            S_STOP:    c = 5'b10111;
            S_CAPTURE: c = 5'b10111;
            S_ACCUM:   c = 5'b10100;
            S_DONE:    c = 5'b11100;
            default:   c = 5'b00000;
        endcase
        return c;
    endfunction

    // Bubble-tolerant decode: number of set bits, whatever their positions.
    function automatic logic [CODE_W-1:0] popcount(input logic [TDC_WIDTH-1:0] v);
        logic [CODE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < TDC_WIDTH; i++) begin
            acc = acc + CODE_W'(v[i]);
        end
        return acc;
    endfunction

`ifdef TDC_BUBBLE_CHECK_EN
    // A clean code 0..01..1 plus one is a power of two (or wraps to zero),
    // so it shares no set bit with itself.
    function automatic logic is_thermometer(input logic [TDC_WIDTH-1:0] v);
        return ((v & (v + TDC_WIDTH'(1'b1))) == '0);
    endfunction
`endif

    state_t                 state_r;
    logic [4:0]             ctl_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [NS_W-1:0]        n_eff_r;
    logic [DLY_W-1:0]       dly_r;
    logic [TDC_WIDTH-1:0]   dout_r;
    logic [CODE_W-1:0]      result_last_r;
    logic [CODE_W-1:0]      result_min_r;
    logic [CODE_W-1:0]      result_max_r;
    logic [SUM_W-1:0]       result_sum_r;
    logic [NS_W-1:0]        sample_cnt_r;
    logic [CODE_W-1:0]      code_s;
    logic                   last_sample_s;
`ifdef TDC_BUBBLE_CHECK_EN
    logic                   therm_ok_s;
    logic                   bubble_err_r;
    logic [NS_W-1:0]        bubble_cnt_r;
`endif

    // Decode of the word registered at the end of CAPTURE; used in ACCUM.
    always_comb begin
        code_s        = popcount(dout_r);
        last_sample_s = ((NS_W+1)'(sample_cnt_r) + (NS_W+1)'(1'b1)) == (NS_W+1)'(n_eff_r);
`ifdef TDC_BUBBLE_CHECK_EN
        therm_ok_s    = is_thermometer(dout_r);
`endif
    end

    // Burst sequencer: state, phase counter, latched config, results.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r       <= S_IDLE;
            ctl_r         <= ctl_for(S_IDLE);
            cnt_r         <= '0;
            n_eff_r       <= '0;
            dly_r         <= '0;
            dout_r        <= '0;
            result_last_r <= '0;
            result_min_r  <= '0;
            result_max_r  <= '0;
            result_sum_r  <= '0;
            sample_cnt_r  <= '0;
`ifdef TDC_BUBBLE_CHECK_EN
            bubble_err_r  <= 1'b0;
            bubble_cnt_r  <= '0;
`endif
        end else if (abort && (state_r != S_IDLE)) begin
            // Cancel: back to idle with the TDC in reset; results keep
            // their partial values and no done pulse is produced.
            state_r <= S_IDLE;
            ctl_r   <= ctl_for(S_IDLE);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_eff_r      <= (num_samples == '0) ? NS_W'(1'b1) : num_samples;
                        dly_r        <= delay_cycles;
                        result_sum_r <= '0;
                        result_max_r <= '0;
                        result_min_r <= '1;
                        sample_cnt_r <= '0;
`ifdef TDC_BUBBLE_CHECK_EN
                        bubble_err_r <= 1'b0;
`endif
                        cnt_r        <= CNT_W'(RST_CYCLES - 1);
                        state_r      <= S_RST;
                        ctl_r        <= ctl_for(S_RST);
                    end else begin
                        state_r <= S_IDLE;
                        ctl_r   <= ctl_for(S_IDLE);
                    end
                end
                S_RST: begin
                    if (cnt_r == '0) begin
                        state_r <= S_ARM;
                        ctl_r   <= ctl_for(S_ARM);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                S_ARM: begin
                    state_r <= S_LAUNCH;
                    ctl_r   <= ctl_for(S_LAUNCH);
                end
                S_LAUNCH: begin
                    // A zero delay skips WAIT entirely.
                    if (dly_r == '0) begin
                        cnt_r   <= CNT_W'(SETTLE_CYCLES - 1);
                        state_r <= S_STOP;
                        ctl_r   <= ctl_for(S_STOP);
                    end else begin
                        cnt_r   <= CNT_W'(dly_r) - CNT_W'(1'b1);
                        state_r <= S_WAIT;
                        ctl_r   <= ctl_for(S_WAIT);
                    end
                end
                S_WAIT: begin
                    if (cnt_r == '0) begin
                        cnt_r   <= CNT_W'(SETTLE_CYCLES - 1);
                        state_r <= S_STOP;
                        ctl_r   <= ctl_for(S_STOP);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                S_STOP: begin
                    if (cnt_r == '0) begin
                        state_r <= S_CAPTURE;
                        ctl_r   <= ctl_for(S_CAPTURE);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                S_CAPTURE: begin
                    dout_r  <= tdc_dout;
                    state_r <= S_ACCUM;
                    ctl_r   <= ctl_for(S_ACCUM);
                end
                S_ACCUM: begin
                    result_last_r <= code_s;
                    result_sum_r  <= result_sum_r + SUM_W'(code_s);
                    if (code_s < result_min_r) begin
                        result_min_r <= code_s;
                    end
                    if (code_s > result_max_r) begin
                        result_max_r <= code_s;
                    end
                    sample_cnt_r  <= sample_cnt_r + NS_W'(1'b1);
`ifdef TDC_BUBBLE_CHECK_EN
                    if (!therm_ok_s) begin
                        bubble_err_r <= 1'b1;
                        if (bubble_cnt_r != '1) begin
                            bubble_cnt_r <= bubble_cnt_r + NS_W'(1'b1);
                        end
                    end
`endif
                    if (last_sample_s) begin
                        state_r <= S_DONE;
                        ctl_r   <= ctl_for(S_DONE);
                    end else begin
                        cnt_r   <= CNT_W'(RST_CYCLES - 1);
                        state_r <= S_RST;
                        ctl_r   <= ctl_for(S_RST);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    ctl_r   <= ctl_for(S_IDLE);
                end
                default: begin
                    state_r <= S_IDLE;
                    ctl_r   <= ctl_for(S_IDLE);
                end
            endcase
        end
    end

    assign busy        = ctl_r[4];
    assign done        = ctl_r[3];
    assign tdc_reset_b = ctl_r[2];
    assign tdc_a       = ctl_r[1];
    assign tdc_b       = ctl_r[0];
    assign result_last = result_last_r;
    assign result_min  = result_min_r;
    assign result_max  = result_max_r;
    assign result_sum  = result_sum_r;
    assign sample_cnt  = sample_cnt_r;
`ifdef TDC_BUBBLE_CHECK_EN
    assign bubble_err  = bubble_err_r;
    assign bubble_cnt  = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_tdc_sample_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tdc_sample_ctrl. Directed steps plus randomized
// bursts; expectations come from the sequencing rules (period and burst
// length formulas, popcount via $countones, min/max/sum over the pattern
// list) rather than from any internal state of the design.
// -----------------------------------------------------------------------------
module tb_tdc_sample_ctrl;

    localparam int TDC_WIDTH     = 252;
    localparam int CODE_W        = 8;
    localparam int NS_W          = 8;
    localparam int DLY_W         = 4;
    localparam int RST_CYCLES    = 2;
    localparam int SETTLE_CYCLES = 2;

    logic                   clk = 1'b0;
    logic                   reset_b;
    logic                   start;
    logic                   abort;
    logic [NS_W-1:0]        num_samples;
    logic [DLY_W-1:0]       delay_cycles;
    logic                   busy, done, tdc_a, tdc_b, tdc_reset_b;
    logic [TDC_WIDTH-1:0]   tdc_dout;
    logic [CODE_W-1:0]      result_last, result_min, result_max;
    logic [CODE_W+NS_W-1:0] result_sum;
    logic [NS_W-1:0]        sample_cnt;
`ifdef TDC_BUBBLE_CHECK_EN
    logic                   bubble_err;
    logic [NS_W-1:0]        bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_bub_cnt = 0;
    logic [TDC_WIDTH-1:0] pat [0:255];

    always #5 clk = ~clk;

    tdc_sample_ctrl dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .delay_cycles (delay_cycles),
        .busy         (busy),
        .done         (done),
        .tdc_a        (tdc_a),
        .tdc_b        (tdc_b),
        .tdc_reset_b  (tdc_reset_b),
        .tdc_dout     (tdc_dout),
        .result_last  (result_last),
        .result_min   (result_min),
        .result_max   (result_max),
        .result_sum   (result_sum),
        .sample_cnt   (sample_cnt)
`ifdef TDC_BUBBLE_CHECK_EN
        ,
        .bubble_err   (bubble_err),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [TDC_WIDTH-1:0] therm(input int c);
        logic [TDC_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < c; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [TDC_WIDTH-1:0] rand_vec();
        logic [TDC_WIDTH-1:0] v;
        for (int i = 0; i < TDC_WIDTH; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Reference for results after `cnt` accumulated samples of pat[].
    task automatic check_results(input int cnt);
        int mn, mx, sm, c;
        bit bub;
        mn = 1000; mx = -1; sm = 0; bub = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            c  = $countones(pat[i]);
            sm = sm + c;
            if (c < mn) mn = c;
            if (c > mx) mx = c;
            if (pat[i] !== therm(c)) begin
                bub = 1'b1;
                if (exp_bub_cnt < 255) exp_bub_cnt++;
            end
        end
        chk("result_last", 32'(result_last), $countones(pat[cnt-1]));
        chk("result_min",  32'(result_min), mn);
        chk("result_max",  32'(result_max), mx);
        chk("result_sum",  32'(result_sum), sm);
        chk("sample_cnt",  32'(sample_cnt), cnt);
`ifdef TDC_BUBBLE_CHECK_EN
        chk("bubble_err",  32'(bubble_err), 32'(bub));
        chk("bubble_cnt",  32'(bubble_cnt), exp_bub_cnt);
`else
        if (bub) c = 0;
`endif
    endtask

    // Runs one burst. Drives pattern k when the TDC leaves reset for sample k.
    // poke_at: cycle at which start is re-pulsed and config inputs changed.
    // abort_samp: sample index in whose WAIT abort is asserted (-1 = none).
    task automatic run_burst(input int n, input int d, input int poke_at,
                             input int abort_samp, output int done_cyc, output int ndone);
        int n_eff, limit, cyc, k, t_a;
        bit prev_rb, prev_a, prev_b, arm_abort;
        n_eff = (n == 0) ? 1 : n;
        limit = n_eff * (RST_CYCLES + SETTLE_CYCLES + d + 4) + 10;
        num_samples  = NS_W'(n);
        delay_cycles = DLY_W'(d);
        done_cyc = -1; ndone = 0; k = 0; t_a = 0;
        prev_rb = 1'b0; prev_a = 1'b0; prev_b = 1'b0; arm_abort = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (cyc < limit) begin
            if (abort) begin
                abort = 1'b0;
                break;
            end
            if (arm_abort) begin
                abort = 1'b1;
                arm_abort = 1'b0;
            end
            if (tdc_reset_b && !prev_rb) begin
                if (k == 0) chk("rst_low_cycles", cyc - 1, RST_CYCLES);
                tdc_dout = pat[k];
                k++;
            end
            if (tdc_a && !prev_a) begin
                t_a = cyc;
                if (abort_samp >= 0 && k == abort_samp + 1) arm_abort = 1'b1;
            end
            if (tdc_b && !prev_b) chk("a_to_b_gap", cyc - t_a, d + 1);
            if (cyc == poke_at) begin
                start        = 1'b1;
                delay_cycles = ~DLY_W'(d);
                num_samples  = NS_W'(n + 3);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                @(negedge clk);
                chk("done_one_cycle", 32'(done), 0);
                chk("idle_after_done", 32'(busy), 0);
                break;
            end
            prev_rb = tdc_reset_b; prev_a = tdc_a; prev_b = tdc_b;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, nd, n, d, ne;
        reset_b = 1'b0; start = 1'b0; abort = 1'b0;
        num_samples = '0; delay_cycles = '0; tdc_dout = '0;
        for (int i = 0; i < 256; i++) pat[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_a",     32'(tdc_a), 0);
        chk("rst_b",     32'(tdc_b), 0);
        chk("rst_tdcrb", 32'(tdc_reset_b), 0);
        chk("rst_min",   32'(result_min), 0);
        chk("rst_cnt",   32'(sample_cnt), 0);
        reset_b = 1'b1;
        @(negedge clk);

        // 1: single sample, no delay, 40-ones code
        pat[0] = therm(40);
        run_burst(1, 0, -1, -1, dc, nd);
        chk("t1_done_cycle", dc, 9);
        chk("t1_done_count", nd, 1);
        check_results(1);

        // 2: four samples, delay 3
        pat[0] = therm(10); pat[1] = therm(200); pat[2] = '0; pat[3] = therm(252);
        run_burst(4, 3, -1, -1, dc, nd);
        chk("t2_done_cycle", dc, 4 * (RST_CYCLES + SETTLE_CYCLES + 3 + 4) + 1);
        check_results(4);
        chk("t2_sum_462", 32'(result_sum), 462);

        // 3: num_samples 0 behaves as 1
        pat[0] = therm(77);
        run_burst(0, 0, -1, -1, dc, nd);
        chk("t3_done_cycle", dc, 9);
        check_results(1);

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", 32'(busy), 0);
        chk("abort_start_idle_cnt",  32'(sample_cnt), 1);

        // 4: abort in WAIT of sample 2 of 5, then clean restart
        pat[0] = therm(33); pat[1] = therm(99);
        run_burst(5, 3, -1, 1, dc, nd);
        chk("t4_no_done", nd, 0);
        chk("t4_busy",    32'(busy), 0);
        chk("t4_a",       32'(tdc_a), 0);
        chk("t4_b",       32'(tdc_b), 0);
        chk("t4_tdcrb",   32'(tdc_reset_b), 0);
        chk("t4_done",    32'(done), 0);
        check_results(1);
        pat[0] = therm(5); pat[1] = therm(6);
        run_burst(2, 1, -1, -1, dc, nd);
        chk("t4_restart_done_cycle", dc, 2 * (RST_CYCLES + SETTLE_CYCLES + 1 + 4) + 1);
        check_results(2);

        // 5: start pulse and config change mid-burst have no effect
        pat[0] = therm(1); pat[1] = therm(120); pat[2] = therm(64);
        run_burst(3, 2, 5, -1, dc, nd);
        chk("t5_done_cycle", dc, 3 * (RST_CYCLES + SETTLE_CYCLES + 2 + 4) + 1);
        check_results(3);

        // 5b: reset mid-burst returns every output to its reset value
        num_samples = 8'd3; delay_cycles = 4'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        chk("t5r_busy",  32'(busy), 0);
        chk("t5r_done",  32'(done), 0);
        chk("t5r_a",     32'(tdc_a), 0);
        chk("t5r_b",     32'(tdc_b), 0);
        chk("t5r_tdcrb", 32'(tdc_reset_b), 0);
        chk("t5r_last",  32'(result_last), 0);
        chk("t5r_min",   32'(result_min), 0);
        chk("t5r_max",   32'(result_max), 0);
        chk("t5r_sum",   32'(result_sum), 0);
        chk("t5r_cnt",   32'(sample_cnt), 0);
        exp_bub_cnt = 0;
        reset_b = 1'b1;
        @(negedge clk);

`ifdef TDC_BUBBLE_CHECK_EN
        // 6: bubbled code 0x0B decodes to 3 and flags a bubble
        pat[0] = '0; pat[0][0] = 1'b1; pat[0][1] = 1'b1; pat[0][3] = 1'b1;
        run_burst(1, 0, -1, -1, dc, nd);
        check_results(1);
        chk("t6_last_3", 32'(result_last), 3);
        chk("t6_err_set", 32'(bubble_err), 1);
        pat[0] = therm(12);
        run_burst(1, 0, -1, -1, dc, nd);
        check_results(1);
`endif

        // Randomized bursts
        for (int t = 0; t < 8; t++) begin
            n  = $urandom_range(0, 6);
            d  = $urandom_range(0, 15);
            ne = (n == 0) ? 1 : n;
            for (int i = 0; i < ne; i++) begin
                pat[i] = ($urandom_range(0, 1) == 0) ? therm($urandom_range(0, TDC_WIDTH)) : rand_vec();
            end
            run_burst(n, d, -1, -1, dc, nd);
            chk("rnd_done_cycle", dc, ne * (RST_CYCLES + SETTLE_CYCLES + d + 4) + 1);
            check_results(ne);
        end

        // 255 samples: counter reaches 255 without wrapping
        for (int i = 0; i < 255; i++) pat[i] = therm($urandom_range(0, TDC_WIDTH));
        run_burst(255, 0, -1, -1, dc, nd);
        chk("n255_done_cycle", dc, 255 * (RST_CYCLES + SETTLE_CYCLES + 4) + 1);
        check_results(255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
